// File: rtl/i2c_reg_access_ctrl.sv
// i2c_reg_access_ctrl
// Turns one host register transaction into a sequence of I2C byte-engine ops.
// The transaction is a 7-bit device address, a 1- or 2-byte register address,
// and then either a single-byte write or a single-byte read after a repeated
// START. The controller reports the read data and an error code.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   i_req_* / o_req_ready   host request channel (accepted only while idle)
//   o_rsp_* / i_rsp_ready   response channel, held until the host accepts it
//   o_busy              high from request accept until the response handshake
//   o_eng_*  / i_eng_ready  byte-engine op channel (flags + write byte)
//   i_eng_done/nack/rdata   byte-engine completion, valid for one cycle
//
// State table
//   state        | meaning
//   S_IDLE       | ready for a request
//   S_ISSUE      | present the current op until the engine takes it
//   S_WAIT       | wait for the op to complete, timer running
//   S_NEXT       | advance to the next op in the list
//   S_ABORT_ISSUE| present a stop-only op after a NACK
//   S_ABORT_WAIT | wait for the stop-only op to complete
//   S_RESP       | hold the response until the host accepts it
module i2c_reg_access_ctrl #(
  parameter int          TIMEOUT_CYC = 100000,
  parameter logic [15:0] ADDR2_DEF   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_rw,
  input  logic [6:0]  i_req_dev,
  input  logic        i_req_a16,
  input  logic [15:0] i_req_reg,
  input  logic [7:0]  i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [7:0]  o_rsp_rdata,
  output logic [1:0]  o_rsp_err,
  output logic        o_busy,
  output logic        o_eng_valid,
  input  logic        i_eng_ready,
  output logic        o_eng_start,
  output logic        o_eng_wr,
  output logic        o_eng_rd,
  output logic        o_eng_stop,
  output logic [7:0]  o_eng_wdata,
  input  logic        i_eng_done,
  input  logic        i_eng_nack,
  input  logic [7:0]  i_eng_rdata
);

  localparam int            TW     = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] T_MAX  = '1;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_TO   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_ABORT_ISSUE,
    S_ABORT_WAIT,
    S_RESP
  } state_t;

  state_t        state;
  logic [2:0]    step;
  logic [TW-1:0] timer;

  logic          rw_q;
  logic [6:0]    dev_q;
  logic          a16_q;
  logic [15:0]   reg_q;
  logic [7:0]    wdata_q;

  logic          rsp_valid_q;
  logic [7:0]    rsp_rdata_q;
  logic [1:0]    rsp_err_q;

  // Current op decoded from the latched request. Ops are numbered on the
  // full (2-byte address) list; with a 1-byte address the hi-byte slot is
  // skipped, so every step after the first shifts up by one.
  logic [2:0] op_idx;
  logic       op_start, op_wr, op_rd, op_stop, op_last;
  logic [7:0] op_wdata;

  always_comb begin
    op_idx   = (!a16_q && step != 3'd0) ? step + 3'd1 : step;
    op_start = 1'b0;
    op_wr    = 1'b0;
    op_rd    = 1'b0;
    op_stop  = 1'b0;
    op_wdata = 8'h00;
    case (op_idx)
      3'd0: begin
        op_start = 1'b1;
        op_wr    = 1'b1;
        op_wdata = {dev_q, 1'b0};
      end
      3'd1: begin
        op_wr    = 1'b1;
        op_wdata = reg_q[15:8];
      end
      3'd2: begin
        op_wr    = 1'b1;
        op_wdata = reg_q[7:0];
      end
      3'd3: begin
        op_wr = 1'b1;
        if (rw_q) begin
          op_start = 1'b1;
          op_wdata = {dev_q, 1'b1};
        end else begin
          op_stop  = 1'b1;
          op_wdata = wdata_q;
        end
      end
      3'd4: begin
        op_rd   = 1'b1;
        op_stop = 1'b1;
      end
      default: ;
    endcase
    op_last = rw_q ? (op_idx == 3'd4) : (op_idx == 3'd3);
  end

  always_comb begin
    o_eng_valid = 1'b0;
    o_eng_start = 1'b0;
    o_eng_wr    = 1'b0;
    o_eng_rd    = 1'b0;
    o_eng_stop  = 1'b0;
    o_eng_wdata = 8'h00;
    if (state == S_ISSUE) begin
      o_eng_valid = 1'b1;
      o_eng_start = op_start;
      o_eng_wr    = op_wr;
      o_eng_rd    = op_rd;
      o_eng_stop  = op_stop;
      o_eng_wdata = op_wdata;
    end else if (state == S_ABORT_ISSUE) begin
      o_eng_valid = 1'b1;
      o_eng_stop  = 1'b1;
    end
  end

  assign o_req_ready = (state == S_IDLE);
  assign o_busy      = (state != S_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      step        <= 3'd0;
      timer       <= '0;
      rw_q        <= 1'b0;
      dev_q       <= 7'h00;
      a16_q       <= 1'b0;
      reg_q       <= 16'h0000;
      wdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= ERR_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            rw_q    <= i_req_rw;
            dev_q   <= i_req_dev;
            a16_q   <= i_req_a16;
            reg_q   <= i_req_reg;
            wdata_q <= i_req_wdata;
            step    <= 3'd0;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_eng_ready) begin
            timer <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // done is checked before the timeout so a late completion still counts
          if (i_eng_done) begin
            if (op_wr && i_eng_nack) begin
              state <= S_ABORT_ISSUE;
            end else if (op_last) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= ERR_OK;
              rsp_rdata_q <= op_rd ? i_eng_rdata : 8'h00;
              state       <= S_RESP;
            end else begin
              state <= S_NEXT;
            end
          end else if (timer == T_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_TO;
            rsp_rdata_q <= 8'h00;
            state       <= S_RESP;
          end else if (timer != T_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        S_NEXT: begin
          step  <= step + 3'd1;
          state <= S_ISSUE;
        end
        S_ABORT_ISSUE: begin
          if (i_eng_ready) begin
            timer <= '0;
            state <= S_ABORT_WAIT;
          end
        end
        S_ABORT_WAIT: begin
          if (i_eng_done) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_NACK;
            rsp_rdata_q <= 8'h00;
            state       <= S_RESP;
          end else if (timer == T_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_TO;
            rsp_rdata_q <= 8'h00;
            state       <= S_RESP;
          end else if (timer != T_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= ERR_OK;
            rsp_rdata_q <= 8'h00;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_access_ctrl.sv
// tb_i2c_reg_access_ctrl
// Directed bench: drives register transactions through the controller while
// a scripted byte engine answers each op, and compares every op and response
// against hand-computed values.
module tb_i2c_reg_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_rw;
  logic [6:0]  i_req_dev;
  logic        i_req_a16;
  logic [15:0] i_req_reg;
  logic [7:0]  i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [7:0]  o_rsp_rdata;
  logic [1:0]  o_rsp_err;
  logic        o_busy;
  logic        o_eng_valid;
  logic        i_eng_ready;
  logic        o_eng_start;
  logic        o_eng_wr;
  logic        o_eng_rd;
  logic        o_eng_stop;
  logic [7:0]  o_eng_wdata;
  logic        i_eng_done;
  logic        i_eng_nack;
  logic [7:0]  i_eng_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  // op flag encoding used below: {start, wr, rd, stop}
  localparam logic [3:0] F_SW = 4'b1100;
  localparam logic [3:0] F_W  = 4'b0100;
  localparam logic [3:0] F_WS = 4'b0101;
  localparam logic [3:0] F_RS = 4'b0011;
  localparam logic [3:0] F_S  = 4'b0001;

  i2c_reg_access_ctrl #(.TIMEOUT_CYC(16), .ADDR2_DEF(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_rw    (i_req_rw),
    .i_req_dev   (i_req_dev),
    .i_req_a16   (i_req_a16),
    .i_req_reg   (i_req_reg),
    .i_req_wdata (i_req_wdata),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_busy      (o_busy),
    .o_eng_valid (o_eng_valid),
    .i_eng_ready (i_eng_ready),
    .o_eng_start (o_eng_start),
    .o_eng_wr    (o_eng_wr),
    .o_eng_rd    (o_eng_rd),
    .o_eng_stop  (o_eng_stop),
    .o_eng_wdata (o_eng_wdata),
    .i_eng_done  (i_eng_done),
    .i_eng_nack  (i_eng_nack),
    .i_eng_rdata (i_eng_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] flags();
    return 32'({o_eng_start, o_eng_wr, o_eng_rd, o_eng_stop});
  endfunction

  // Called on a negedge; leaves the request accepted and checks the first op
  // is already presented one cycle after the accept.
  task automatic send_req(input logic rw, input logic [6:0] dev, input logic a16,
                          input logic [15:0] rg, input logic [7:0] wd);
    i_req_rw    = rw;
    i_req_dev   = dev;
    i_req_a16   = a16;
    i_req_reg   = rg;
    i_req_wdata = wd;
    i_req_valid = 1'b1;
    check_val("req_ready idle", 32'(o_req_ready), 32'd1);
    @(negedge clk);
    i_req_valid = 1'b0;
    check_val("busy after accept", 32'(o_busy), 32'd1);
    check_val("eng_valid after accept", 32'(o_eng_valid), 32'd1);
  endtask

  // Scripted engine: waits for an op, checks it, accepts it, then one cycle
  // later pulses done with the given nack/rdata.
  task automatic serve(input string tag, input logic [3:0] ef, input logic [7:0] ewd,
                       input logic nack, input logic [7:0] rd);
    int n = 0;
    while (!o_eng_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, " valid"}, 32'(o_eng_valid), 32'd1);
    check_val({tag, " flags"}, flags(), 32'(ef));
    if (ef[2]) check_val({tag, " wdata"}, 32'(o_eng_wdata), 32'(ewd));
    i_eng_ready = 1'b1;
    @(negedge clk);
    i_eng_ready = 1'b0;
    check_val({tag, " valid drops"}, 32'(o_eng_valid), 32'd0);
    @(negedge clk);
    i_eng_done  = 1'b1;
    i_eng_nack  = nack;
    i_eng_rdata = rd;
    @(negedge clk);
    i_eng_done  = 1'b0;
    i_eng_nack  = 1'b0;
    i_eng_rdata = 8'h00;
  endtask

  task automatic get_rsp(input string tag, input logic [1:0] err, input logic [7:0] rdata);
    int n = 0;
    while (!o_rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, " rsp_valid"}, 32'(o_rsp_valid), 32'd1);
    check_val({tag, " rsp_err"}, 32'(o_rsp_err), 32'(err));
    check_val({tag, " rsp_rdata"}, 32'(o_rsp_rdata), 32'(rdata));
    check_val({tag, " no op in resp"}, 32'(o_eng_valid), 32'd0);
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    check_val({tag, " rsp cleared"}, 32'({o_rsp_valid, o_rsp_err, o_rsp_rdata}), 32'd0);
    check_val({tag, " back idle"}, 32'({o_req_ready, o_busy}), 32'b10);
  endtask

  initial begin
    int cnt;
    logic stable;

    rst         = 1'b1;
    i_req_valid = 1'b0;
    i_req_rw    = 1'b0;
    i_req_dev   = 7'h00;
    i_req_a16   = 1'b0;
    i_req_reg   = 16'h0000;
    i_req_wdata = 8'h00;
    i_rsp_ready = 1'b0;
    i_eng_ready = 1'b0;
    i_eng_done  = 1'b0;
    i_eng_nack  = 1'b0;
    i_eng_rdata = 8'h00;
    repeat (3) @(negedge clk);
    check_val("reset req_ready", 32'(o_req_ready), 32'd1);
    check_val("reset outs", 32'({o_busy, o_eng_valid, o_rsp_valid, o_rsp_err, o_rsp_rdata}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1-byte address write
    send_req(1'b0, 7'h3C, 1'b0, 16'h0012, 8'hA5);
    serve("wr op0", F_SW, 8'h78, 1'b0, 8'h00);
    serve("wr op1", F_W,  8'h12, 1'b0, 8'h00);
    serve("wr op2", F_WS, 8'hA5, 1'b0, 8'h00);
    get_rsp("wr", 2'd0, 8'h00);

    // 2-byte address read; the master NACK on the read byte must be ignored
    send_req(1'b1, 7'h50, 1'b1, 16'h0102, 8'hEE);
    serve("rd op0", F_SW, 8'hA0, 1'b0, 8'h00);
    serve("rd op1", F_W,  8'h01, 1'b0, 8'h00);
    serve("rd op2", F_W,  8'h02, 1'b0, 8'h00);
    serve("rd op3", F_SW, 8'hA1, 1'b0, 8'h00);
    serve("rd op4", F_RS, 8'h00, 1'b1, 8'h5A);
    get_rsp("rd", 2'd0, 8'h5A);

    // NACK on the device byte -> stop-only op, err=1
    send_req(1'b0, 7'h3C, 1'b1, 16'h1234, 8'h99);
    serve("nk op0", F_SW, 8'h78, 1'b1, 8'h00);
    serve("nk stop", F_S, 8'h00, 1'b0, 8'h00);
    get_rsp("nk", 2'd1, 8'h00);

    // engine never completes -> timeout 16 cycles after the op handshake
    send_req(1'b0, 7'h3C, 1'b0, 16'h0012, 8'hA5);
    i_eng_ready = 1'b1;
    @(negedge clk);
    i_eng_ready = 1'b0;
    cnt = 0;
    while (!o_rsp_valid && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_val("timeout latency", 32'(cnt), 32'd16);
    @(negedge clk);
    get_rsp("to", 2'd2, 8'h00);

    // done on the very cycle the timer reaches its limit: done wins
    send_req(1'b0, 7'h3C, 1'b0, 16'h0012, 8'h5A);
    i_eng_ready = 1'b1;
    @(negedge clk);
    i_eng_ready = 1'b0;
    repeat (15) @(negedge clk);
    i_eng_done = 1'b1;
    @(negedge clk);
    i_eng_done = 1'b0;
    serve("late op1", F_W,  8'h12, 1'b0, 8'h00);
    serve("late op2", F_WS, 8'h5A, 1'b0, 8'h00);
    get_rsp("late", 2'd0, 8'h00);

    // response back-pressure with a new request waiting
    send_req(1'b0, 7'h21, 1'b1, 16'hBEEF, 8'h33);
    serve("bp op0", F_SW, 8'h42, 1'b0, 8'h00);
    serve("bp op1", F_W,  8'hBE, 1'b0, 8'h00);
    serve("bp op2", F_W,  8'hEF, 1'b0, 8'h00);
    serve("bp op3", F_WS, 8'h33, 1'b0, 8'h00);
    i_req_valid = 1'b1;
    i_req_dev   = 7'h11;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (o_req_ready !== 1'b0 || o_rsp_valid !== 1'b1 || o_rsp_err !== 2'd0 ||
          o_rsp_rdata !== 8'h00 || o_eng_valid !== 1'b0)
        stable = 1'b0;
      @(negedge clk);
    end
    check_val("bp held stable", 32'(stable), 32'd1);
    i_req_valid = 1'b0;
    get_rsp("bp", 2'd0, 8'h00);

    // reset during the third op's WAIT
    send_req(1'b0, 7'h3C, 1'b0, 16'h0012, 8'hA5);
    serve("rs op0", F_SW, 8'h78, 1'b0, 8'h00);
    serve("rs op1", F_W,  8'h12, 1'b0, 8'h00);
    cnt = 0;
    while (!o_eng_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check_val("rs op2 flags", flags(), 32'(F_WS));
    i_eng_ready = 1'b1;
    @(negedge clk);
    i_eng_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_val("rst eng_valid", 32'(o_eng_valid), 32'd0);
    check_val("rst req_ready", 32'(o_req_ready), 32'd1);
    check_val("rst busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1-byte address read after reset recovery
    send_req(1'b1, 7'h7F, 1'b0, 16'h0080, 8'h00);
    serve("rr op0", F_SW, 8'hFE, 1'b0, 8'h00);
    serve("rr op1", F_W,  8'h80, 1'b0, 8'h00);
    serve("rr op2", F_SW, 8'hFF, 1'b0, 8'h00);
    serve("rr op3", F_RS, 8'h00, 1'b0, 8'hC3);
    get_rsp("rr", 2'd0, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
